// File: rtl/mem_arbiter.sv
// Round-robin two-master arbiter for the valid/ready memory bus.
// The grant is held for a whole transaction, and a watchdog ends any access that the slave never acknowledges.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        owner,
  output logic        timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          pick_m1;

  // A tie goes to the master that did not win last time.
  always_comb begin
    pick_m1 = m1_valid;
    if (m0_valid && m1_valid) pick_m1 = ~owner;
  end

  // NOTE: all state lives in one clocked block with non-blocking assignments, so every
  // register reads the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b1;
      count    <= '0;
      s_valid  <= 1'b0;
      s_instr  <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      timeout  <= 1'b0;
    end else begin
      // NOTE: the ready and timeout pulses default low every cycle and are raised only on
      // the completing edge, which guarantees they last exactly one cycle.
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            owner   <= pick_m1;
            s_instr <= pick_m1 ? 1'b0 : m0_instr;
            s_addr  <= pick_m1 ? m1_addr  : m0_addr;
            s_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            s_wstrb <= pick_m1 ? m1_wstrb : m0_wstrb;
            count   <= '0;
            s_valid <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (s_ready || count == LAST_COUNT) begin
            // A watchdog termination returns zero data to the master.
            s_valid <= 1'b0;
            timeout <= ~s_ready;
            state   <= DONE;
            if (owner) begin
              m1_ready <= 1'b1;
              m1_rdata <= s_ready ? s_rdata : 32'h0;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= s_ready ? s_rdata : 32'h0;
            end
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of grant order and completion timing.
module tb_mem_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready, s_valid, s_instr, s_ready, owner, timeout;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Master-side request state and model expectations.
  logic        rv[2];
  logic [31:0] ra[2], rd[2];
  logic [3:0]  rs[2];
  logic        ri0;
  logic [31:0] exp_rdata[2];
  int          last_owner;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    m0_valid = rv[0]; m0_addr = ra[0]; m0_wdata = rd[0]; m0_wstrb = rs[0]; m0_instr = ri0;
    m1_valid = rv[1]; m1_addr = ra[1]; m1_wdata = rd[1]; m1_wstrb = rs[1];
  endtask

  task automatic new_req(input int m);
    rv[m] = 1'b1;
    ra[m] = $urandom;
    rd[m] = $urandom;
    rs[m] = 4'($urandom);
    if (m == 0) ri0 = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".s_valid"}, s_valid, 0);
    check({tag, ".s_addr"}, s_addr, 0);
    check({tag, ".s_wdata"}, s_wdata, 0);
    check({tag, ".s_wstrb"}, s_wstrb, 0);
    check({tag, ".s_instr"}, s_instr, 0);
    check({tag, ".m0_ready"}, m0_ready, 0);
    check({tag, ".m1_ready"}, m1_ready, 0);
    check({tag, ".m0_rdata"}, m0_rdata, 0);
    check({tag, ".m1_rdata"}, m1_rdata, 0);
    check({tag, ".timeout"}, timeout, 0);
    check({tag, ".owner"}, owner, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rv[0] = 1'b0; rv[1] = 1'b0;
    s_ready = 1'b0;
    apply();
    step();
    step();
    reset = 1'b0;
    last_owner = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    check_reset_outputs("reset");
  endtask

  // One transaction, starting in an IDLE cycle with at least one valid request.
  // lat: cycle (relative to grant) when the slave answers; beyond T means never.
  // renew: 0 winner drops valid, 1 winner re-requests, 2 random choice.
  task automatic run_txn(input int lat, input logic [31:0] sdata, input bit perturb, input int renew);
    int winner, fin;
    bit to;
    logic [31:0] ca, cd;
    logic [3:0] cs;
    logic ci;
    if (rv[0] && rv[1]) winner = (last_owner == 0) ? 1 : 0;
    else                winner = rv[1] ? 1 : 0;
    ca = ra[winner]; cd = rd[winner]; cs = rs[winner];
    ci = (winner == 0) ? ri0 : 1'b0;
    to  = (lat > T);
    fin = to ? T : lat;
    for (int c = 1; c <= fin; c++) begin
      step();
      check("busy.s_valid", s_valid, 1);
      check("busy.s_addr", s_addr, ca);
      check("busy.s_wdata", s_wdata, cd);
      check("busy.s_wstrb", s_wstrb, cs);
      check("busy.s_instr", s_instr, ci);
      check("busy.owner", owner, 32'(winner));
      check("busy.m0_ready", m0_ready, 0);
      check("busy.m1_ready", m1_ready, 0);
      check("busy.timeout", timeout, 0);
      s_ready = (c == lat);
      s_rdata = (c == lat) ? sdata : $urandom;
      if (perturb && c == 1) begin ra[winner] = $urandom; rd[winner] = $urandom; rs[winner] = ~cs; end
      if (perturb && c == 2) rv[winner] = 1'b0;
      if (renew == 2 && !rv[1-winner] && $urandom_range(0, 3) == 0) new_req(1 - winner);
      apply();
    end
    step();
    s_ready = 1'b0;
    exp_rdata[winner] = to ? 32'h0 : sdata;
    check("done.m0_ready", m0_ready, 32'(winner == 0));
    check("done.m1_ready", m1_ready, 32'(winner == 1));
    check("done.m0_rdata", m0_rdata, exp_rdata[0]);
    check("done.m1_rdata", m1_rdata, exp_rdata[1]);
    check("done.timeout", timeout, 32'(to));
    check("done.s_valid", s_valid, 0);
    check("done.owner", owner, 32'(winner));
    last_owner = winner;
    rv[winner] = 1'b0;
    if (renew == 1 || (renew == 2 && $urandom_range(0, 1) == 1)) new_req(winner);
    apply();
    step();
    check("gap.s_valid", s_valid, 0);
    check("gap.m0_ready", m0_ready, 0);
    check("gap.m1_ready", m1_ready, 0);
    check("gap.timeout", timeout, 0);
  endtask

  initial begin
    ra[0] = '0; ra[1] = '0; rd[0] = '0; rd[1] = '0; rs[0] = '0; rs[1] = '0; ri0 = 1'b0;
    s_rdata = '0;
    do_reset();

    // m0 read answered on cycle 3.
    rv[0] = 1'b1; ri0 = 1'b0; ra[0] = 32'h4000_0010; rd[0] = '0; rs[0] = 4'b0000;
    apply();
    run_txn(3, 32'hDEAD_BEEF, 1'b0, 0);

    // Simultaneous requests after reset alternate, starting with m0.
    do_reset();
    new_req(0); new_req(1); apply();
    for (int i = 0; i < 6; i++) run_txn(1, $urandom, 1'b0, 1);

    // m1 write; m0 withdraws before the grant.
    rv[0] = 1'b0; rv[1] = 1'b1; ra[1] = 32'hC300_0004; rd[1] = 32'h1234_5678; rs[1] = 4'b0011;
    apply();
    run_txn(2, $urandom, 1'b0, 0);

    // Watchdog: never answered, answered on the last legal cycle, one cycle too late.
    new_req(0); apply(); run_txn(99, $urandom, 1'b0, 0);
    new_req(0); apply(); run_txn(T, $urandom, 1'b0, 0);
    new_req(1); apply(); run_txn(T + 1, $urandom, 1'b0, 0);

    // Reset during the second BUSY cycle abandons the access; m0 then restarts.
    new_req(0); apply();
    step();
    step();
    check("rst_mid.s_valid_before", s_valid, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    #2;
    reset = 1'b0;
    last_owner = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    run_txn(2, $urandom, 1'b0, 0);

    // Granted master changes its fields and drops valid mid-access.
    new_req(0); apply();
    run_txn(3, $urandom, 1'b1, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      if (!rv[0] && !rv[1]) begin
        if ($urandom_range(0, 2) != 0) new_req(0);
        if ($urandom_range(0, 2) != 0) new_req(1);
        apply();
      end
      if (!rv[0] && !rv[1]) begin
        step();
        check("idle.s_valid", s_valid, 0);
      end else begin
        run_txn($urandom_range(1, T + 2), $urandom, 1'($urandom_range(0, 3) == 0), 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
